noc_inject_arbiter: RTL and testbench

- Shares one router local-injection port among NUM_REQ local flit sources, e.g. several PE traffic generators or a PE plus a DMA.
- Round-robin arbitration over a valid/ready handshake into a one-entry registered output stage.
- Optional global packet budget; forwarded-flit counter for bench statistics.
- Sits between the PE-side sources and the router input port of one mesh node.

---
 rtl/noc_inject_arbiter.sv | 144 ++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module : noc_inject_arbiter
// Round-robin merge of NUM_REQ local flit sources into one registered
// router injection port, with an optional global flit budget.
// Rev    : 1.0  initial release
// ============================================================================
module noc_inject_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 37,
  parameter int PKT_LIMIT  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_data_valid,
  input  logic                          i_data_ready,
  output logic [31:0]                   o_fwd_count,
  output logic                          o_limit_reached,
  output logic                          o_idle
);

  localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   c_num_req = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQ-1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [PTR_W:0]        w_sum;
  logic [NUM_REQ-1:0]    w_cand;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_found;
  logic                  w_load;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_limit;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [31:0]           r_fwd;

  assign w_load = (r_state == EMPTY) || i_data_ready;
  assign w_cand = i_req_valid & {NUM_REQ{i_enable & ~w_limit}};

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_sum >= c_num_req) begin
        w_sum = w_sum - c_num_req;
      end
      if (!w_found && w_cand[w_sum[PTR_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_found) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  // Ready is forced low while the asynchronous reset is held.
  assign o_req_ready = w_grant & {NUM_REQ{w_load & rst}};
  assign w_in_xfer   = |(i_req_valid & o_req_ready);
  assign w_out_xfer  = (r_state == FULL) && i_data_ready;
  assign w_ptr_nxt   = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel_data  = i_req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_in_xfer) w_state_nxt = FULL;
      FULL:    if (w_out_xfer && !w_in_xfer) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_fwd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_xfer) begin
        r_data <= w_sel_data;
        r_ptr  <= w_ptr_nxt;
      end
      if (w_out_xfer && (r_fwd != 32'hFFFF_FFFF)) begin
        r_fwd <= r_fwd + 32'd1;
      end
    end
  end

  generate
    if (PKT_LIMIT != 0) begin : g_budget
      logic [31:0] r_acc;
      logic        r_limit;
      // Limit flag latches on the accept that reaches the budget; no grant
      // can follow, so the count never passes PKT_LIMIT.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_acc   <= '0;
          r_limit <= 1'b0;
        end else if (w_in_xfer) begin
          r_acc <= r_acc + 32'd1;
          if ((r_acc + 32'd1) == 32'(PKT_LIMIT)) begin
            r_limit <= 1'b1;
          end
        end
      end
      assign w_limit = r_limit;
    end else begin : g_unlimited
      assign w_limit = 1'b0;
    end
  endgenerate

  assign o_data          = r_data;
  assign o_data_valid    = (r_state == FULL);
  assign o_fwd_count     = r_fwd;
  assign o_limit_reached = w_limit;
  assign o_idle          = (r_state == EMPTY) && (w_limit || !i_enable);

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_noc_inject_arbiter
// Directed plus random stimulus against a spec-level arbiter model; two DUTs
// (unlimited and PKT_LIMIT=6) share all inputs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_noc_inject_arbiter;

  localparam int N = 4;
  localparam int W = 37;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           drdy = 1'b0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_valid = '0;

  logic [N-1:0]   rdy_o [2];
  logic [W-1:0]   dat_o [2];
  logic           dv_o  [2];
  logic [31:0]    fwd_o [2];
  logic           lim_o [2];
  logic           idle_o[2];

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per DUT
  int           lim_p [2] = '{0, 6};
  bit           m_full[2];
  logic [W-1:0] m_data[2];
  int           m_ptr [2];
  logic [31:0]  m_fwd [2];
  int           m_acc [2];
  bit           m_lim [2];
  logic [N-1:0] m_rdy [2];

  always #5 clk = ~clk;

  noc_inject_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .PKT_LIMIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_enable(en), .i_req_data(req_data),
    .i_req_valid(req_valid), .o_req_ready(rdy_o[0]), .o_data(dat_o[0]),
    .o_data_valid(dv_o[0]), .i_data_ready(drdy), .o_fwd_count(fwd_o[0]),
    .o_limit_reached(lim_o[0]), .o_idle(idle_o[0])
  );

  noc_inject_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .PKT_LIMIT(6)) u_dut1 (
    .clk(clk), .rst(rst), .i_enable(en), .i_req_data(req_data),
    .i_req_valid(req_valid), .o_req_ready(rdy_o[1]), .o_data(dat_o[1]),
    .o_data_valid(dv_o[1]), .i_data_ready(drdy), .o_fwd_count(fwd_o[1]),
    .o_limit_reached(lim_o[1]), .o_idle(idle_o[1])
  );

  function automatic logic [W-1:0] flit(int k, logic [31:0] p);
    return {1'b1, 3'(k), 1'b0, p};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 0; m_data[d] = '0; m_ptr[d] = 0;
      m_fwd[d] = '0; m_acc[d] = 0; m_lim[d] = 0;
    end
  endtask

  // First valid requester at or after the pointer, if a grant is allowed now.
  function automatic logic [N-1:0] exp_ready(int d);
    logic [N-1:0] r;
    r = '0;
    if (rst && (!m_full[d] || drdy) && en && !m_lim[d]) begin
      for (int k = 0; k < N; k++) begin
        if (r == '0 && req_valid[(m_ptr[d] + k) % N]) r[(m_ptr[d] + k) % N] = 1'b1;
      end
    end
    return r;
  endfunction

  // Inputs are applied by the caller just after a falling edge.
  task automatic tick();
    #2;
    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = exp_ready(d);
      chk($sformatf("d%0d_ready", d), 64'(rdy_o[d]), 64'(m_rdy[d]));
      chk($sformatf("d%0d_valid", d), 64'(dv_o[d]), 64'(m_full[d]));
      chk($sformatf("d%0d_data", d), 64'(dat_o[d]), 64'(m_data[d]));
      chk($sformatf("d%0d_fwd", d), 64'(fwd_o[d]), 64'(m_fwd[d]));
      chk($sformatf("d%0d_limit", d), 64'(lim_o[d]), 64'(m_lim[d]));
      chk($sformatf("d%0d_idle", d), 64'(idle_o[d]), 64'(!m_full[d] && (m_lim[d] || !en)));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      bit out_x;
      out_x = m_full[d] && drdy;
      if (out_x && m_fwd[d] != 32'hFFFF_FFFF) m_fwd[d]++;
      if (m_rdy[d] != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_rdy[d][k]) begin
            m_data[d] = req_data[k*W +: W];
            m_ptr[d]  = (k + 1) % N;
          end
        end
        m_full[d] = 1;
        m_acc[d]++;
        if (lim_p[d] != 0 && m_acc[d] == lim_p[d]) m_lim[d] = 1;
      end else if (out_x) begin
        m_full[d] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_payloads(logic [31:0] base);
    for (int k = 0; k < N; k++) req_data[k*W +: W] = flit(k, base + 32'(k));
  endtask

  initial begin
    // Reset state, with requests pending to confirm ready stays low
    model_reset();
    en = 1'b1; drdy = 1'b1; req_valid = 4'hF; set_payloads(32'h50);
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 64'(rdy_o[d]), 64'h0);
      chk("rst_valid", 64'(dv_o[d]), 64'h0);
      chk("rst_data", 64'(dat_o[d]), 64'h0);
      chk("rst_fwd", 64'(fwd_o[d]), 64'h0);
      chk("rst_limit", 64'(lim_o[d]), 64'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Round robin: payloads A0+k, all valid, ready high
    set_payloads(32'hA0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_payload", 64'(dat_o[0][31:0]), 64'(32'hA0 + 32'(i % 4)));
    end
    req_valid = '0;
    tick();
    chk("rr_fwd8", 64'(fwd_o[0]), 64'd8);
    chk("budget_fwd6", 64'(fwd_o[1]), 64'd6);
    chk("budget_limit", 64'(lim_o[1]), 64'd1);
    chk("budget_idle", 64'(idle_o[1]), 64'd1);

    // Backpressure: requester 2 sends 0x1234, router stalls 3 cycles
    req_data[2*W +: W] = flit(2, 32'h1234);
    req_valid = 4'b0100; drdy = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'(rdy_o[0]), 64'h0);
      chk("bp_hold", 64'(dat_o[0][31:0]), 64'h1234);
      chk("bp_valid", 64'(dv_o[0]), 64'h1);
      tick();
    end
    req_valid = '0; drdy = 1'b1;
    tick();
    chk("bp_drained", 64'(dv_o[0]), 64'h0);
    chk("bp_one_xfer", 64'(fwd_o[0]), 64'd9);

    // Sparse: move pointer to 2 via requester 1, then 1 and 3 valid
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sparse_grant", 64'(rdy_o[0]), 64'((i % 2 == 0) ? 4'b1000 : 4'b0010));
      tick();
    end

    // Enable gating while FULL with router stalled
    req_valid = 4'hF; en = 1'b0; drdy = 1'b0;
    #1;
    chk("en_no_grant", 64'(rdy_o[0]), 64'h0);
    chk("en_held", 64'(dv_o[0]), 64'h1);
    tick();
    drdy = 1'b1;
    tick();
    #1;
    chk("en_drained", 64'(dv_o[0]), 64'h0);
    chk("en_idle", 64'(idle_o[0]), 64'h1);
    chk("en_still_off", 64'(rdy_o[0]), 64'h0);
    en = 1'b1;
    #1;
    chk("en_resume_ptr", 64'(rdy_o[0]), 64'b0100);
    tick();

    // Reset mid-stream
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(dv_o[0]), 64'h0);
    chk("midrst_fwd", 64'(fwd_o[0]), 64'h0);
    chk("midrst_ready", 64'(rdy_o[0]), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_first", 64'(rdy_o[0]), 64'b0001);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) req_data[k*W +: W] = W'({$urandom, $urandom});
      req_valid = N'($urandom);
      drdy      = ($urandom_range(0, 9) < 7);
      en        = ($urandom_range(0, 9) < 9);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
